// File: rtl/jt51_pm_seq.sv
// Pitch-modulation sweep sequencer: walks channels 0..7 through one shared PM adder.
// Optional `JT51_PM_SKIP_EN: channels with pms=0 skip the write cycle.
module jt51_pm_seq (
   input  logic        rst,
   input  logic        clk,
   input  logic        cen,
   input  logic        start,
   input  logic [7:0]  lfo_pm,
   input  logic [6:0]  pmd,
   output logic [2:0]  ch_addr,
   input  logic [6:0]  ch_kc,
   input  logic [5:0]  ch_kf,
   input  logic [2:0]  ch_pms,
   output logic [6:0]  pm_kc,
   output logic [5:0]  pm_kf,
   output logic [8:0]  pm_mod,
   output logic        pm_add,
   input  logic [12:0] pm_kcex,
   output logic        kcex_we,
   output logic [2:0]  kcex_ch,
   output logic [12:0] kcex,
   output logic        busy,
   output logic        done
);

   typedef enum logic [1:0] {IDLE, RD, CALC, WR} state_t;

   state_t      state_q, state_d;
   logic [2:0]  ch_q, ch_d;
   logic        pend_q, pend_d;
   logic        done_q, done_d;
   logic        snap, sweep_end;

   logic [7:0]  lfo_q;
   logic [6:0]  pmd_q;
   logic [6:0]  kc_q;
   logic [5:0]  kf_q;
   logic [8:0]  mod_q;
   logic        add_q;

   logic [6:0]  mag;
   logic [6:0]  prod;
   logic [8:0]  prod9;
   logic [8:0]  mod_c;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ch_q    <= '0;
         pend_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (cen) begin
         state_q <= state_d;
         ch_q    <= ch_d;
         pend_q  <= pend_d;
         done_q  <= done_d;
      end
   end

   // A start seen on the final write cycle counts as pending and restarts directly.
   always_comb begin
      state_d   = state_q;
      ch_d      = ch_q;
      pend_d    = pend_q | (start && (state_q != IDLE));
      done_d    = 1'b0;
      snap      = 1'b0;
      sweep_end = 1'b0;
      case (state_q)
         IDLE: begin
            if (start) begin
               state_d = RD;
               ch_d    = '0;
               snap    = 1'b1;
            end
         end
         RD:   state_d = CALC;
         CALC: begin
            state_d = WR;
`ifdef JT51_PM_SKIP_EN
            if (ch_pms == 3'd0) begin
               if (ch_q == 3'd7) begin
                  sweep_end = 1'b1;
               end else begin
                  ch_d    = ch_q + 3'd1;
                  state_d = RD;
               end
            end
`endif
         end
         WR: begin
            if (ch_q == 3'd7) begin
               sweep_end = 1'b1;
            end else begin
               ch_d    = ch_q + 3'd1;
               state_d = RD;
            end
         end
         default: state_d = IDLE;
      endcase
      if (sweep_end) begin
         done_d = 1'b1;
         ch_d   = '0;
         pend_d = 1'b0;
         if (pend_q || start) begin
            state_d = RD;
            snap    = 1'b1;
         end else begin
            state_d = IDLE;
         end
      end
   end

   always_comb begin
      mag = lfo_q[7] ? 7'(8'd0 - lfo_q) : lfo_q[6:0];
      if (lfo_q == 8'h80) mag = 7'd127;
      prod  = 7'(({7'd0, mag} * {7'd0, pmd_q}) >> 7);
      prod9 = {2'b00, prod};
      case (ch_pms)
         3'd0:    mod_c = '0;
         3'd1:    mod_c = prod9 >> 5;
         3'd2:    mod_c = prod9 >> 4;
         3'd3:    mod_c = prod9 >> 3;
         3'd4:    mod_c = prod9 >> 2;
         3'd5:    mod_c = prod9 >> 1;
         3'd6:    mod_c = prod9 << 2;
         default: mod_c = prod[6] ? 9'd511 : {prod[5:0], 3'b000};
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lfo_q <= '0;
         pmd_q <= '0;
         kc_q  <= '0;
         kf_q  <= '0;
         mod_q <= '0;
         add_q <= 1'b0;
      end else if (cen) begin
         if (snap) begin
            lfo_q <= lfo_pm;
            pmd_q <= pmd;
         end
         if (state_q == CALC) begin
            kc_q  <= ch_kc;
            kf_q  <= ch_kf;
            mod_q <= mod_c;
            add_q <= ~lfo_q[7];
         end
      end
   end

   always_comb begin
      ch_addr = ch_q;
      kcex_we = (state_q == WR);
      kcex_ch = ch_q;
      kcex    = (state_q == WR) ? pm_kcex : '0;
      busy    = (state_q != IDLE);
      done    = done_q;
      pm_kc   = kc_q;
      pm_kf   = kf_q;
      pm_mod  = mod_q;
      pm_add  = add_q;
   end

endmodule

// File: tb/tb_jt51_pm_seq.sv
// Directed bench for jt51_pm_seq with a channel-register model and a PM adder model.
module tb_jt51_pm_seq;

   logic        clk = 1'b0;
   logic        rst, cen, start;
   logic [7:0]  lfo_pm;
   logic [6:0]  pmd;
   logic [2:0]  ch_addr;
   logic [6:0]  ch_kc;
   logic [5:0]  ch_kf;
   logic [2:0]  ch_pms;
   logic [6:0]  pm_kc;
   logic [5:0]  pm_kf;
   logic [8:0]  pm_mod;
   logic        pm_add;
   logic [12:0] pm_kcex;
   logic        kcex_we;
   logic [2:0]  kcex_ch;
   logic [12:0] kcex;
   logic        busy, done;

   jt51_pm_seq dut (
      .rst(rst), .clk(clk), .cen(cen), .start(start),
      .lfo_pm(lfo_pm), .pmd(pmd), .ch_addr(ch_addr),
      .ch_kc(ch_kc), .ch_kf(ch_kf), .ch_pms(ch_pms),
      .pm_kc(pm_kc), .pm_kf(pm_kf), .pm_mod(pm_mod), .pm_add(pm_add),
      .pm_kcex(pm_kcex), .kcex_we(kcex_we), .kcex_ch(kcex_ch), .kcex(kcex),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   // channel register file with one cen-cycle read latency
   logic [6:0] kc_tab [8];
   logic [5:0] kf_tab [8];
   logic [2:0] pms_tab [8];
   logic [2:0] rd_q = '0;
   always @(posedge clk) if (cen) rd_q <= ch_addr;
   assign ch_kc  = kc_tab[rd_q];
   assign ch_kf  = kf_tab[rd_q];
   assign ch_pms = pms_tab[rd_q];

   // shared PM adder
   assign pm_kcex = pm_add ? ({pm_kc, pm_kf} + {4'd0, pm_mod})
                           : ({pm_kc, pm_kf} - {4'd0, pm_mod});

   int total = 0, bad = 0;
   int cyc = 0, clk_cnt = 0, k_cen = 0, k_clk = 0;
   int nw = 0, nd = 0, we_clks = 0;
   int wr_cyc [32], wr_clk [32], wr_ch [32], wr_val [32], wr_mod [32], wr_add [32];
   int done_cyc [8];
   logic busy_log [64];
   int e_n = 0;
   int e_cyc [32], e_ch [32], e_mod [32], e_add [32];

   always @(posedge clk) begin
      clk_cnt++;
      if (cen) cyc++;
   end

   always @(negedge clk) begin
      if (kcex_we) we_clks++;
      if (cen) begin
         if ((cyc - k_cen) >= 0 && (cyc - k_cen) < 64) busy_log[cyc - k_cen] = busy;
         if (kcex_we && nw < 32) begin
            wr_cyc[nw] = cyc - k_cen;
            wr_clk[nw] = clk_cnt - k_clk;
            wr_ch[nw]  = int'(kcex_ch);
            wr_val[nw] = int'(kcex);
            wr_mod[nw] = int'(pm_mod);
            wr_add[nw] = int'(pm_add);
            nw++;
         end
         if (done && nd < 8) begin
            done_cyc[nd] = cyc - k_cen;
            nd++;
         end
      end
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   function automatic logic [63:0] out_vec();
      return {19'd0, ch_addr, pm_kc, pm_kf, pm_mod, pm_add, kcex_we, kcex_ch, kcex, busy, done};
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_pms(input logic [23:0] v);
      for (int i = 0; i < 8; i++) begin
         kc_tab[i]  = 7'(16 + 3 * i);
         kf_tab[i]  = 6'(5 * i);
         pms_tab[i] = v[3*i +: 3];
      end
   endtask

   task automatic clear();
      nw = 0; nd = 0; we_clks = 0; e_n = 0;
   endtask

   task automatic expect_wr(input int c, input int ch, input int m, input int a);
      e_cyc[e_n] = c; e_ch[e_n] = ch; e_mod[e_n] = m; e_add[e_n] = a;
      e_n++;
   endtask

   task automatic kick();
      start = 1'b1;
      cen   = 1'b1;
      k_cen = cyc + 1;
      k_clk = clk_cnt + 1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done(input string t, input int n, input int budget);
      for (int i = 0; i < budget && nd < n; i++) tick();
      check({t, "_done_seen"}, 64'(nd >= n), 1);
      repeat (4) tick();
   endtask

   task automatic verify(input string t);
      int base, kv;
      check({t, "_nwr"}, nw, e_n);
      for (int i = 0; i < e_n && i < nw; i++) begin
         base = int'({kc_tab[e_ch[i]], kf_tab[e_ch[i]]});
         kv   = (e_add[i] != 0 ? base + e_mod[i] : base - e_mod[i]) & 8191;
         check($sformatf("%s_w%0d_cyc", t, i), wr_cyc[i], e_cyc[i]);
         check($sformatf("%s_w%0d_ch", t, i), wr_ch[i], e_ch[i]);
         check($sformatf("%s_w%0d_mod", t, i), wr_mod[i], e_mod[i]);
         check($sformatf("%s_w%0d_add", t, i), wr_add[i], e_add[i]);
         check($sformatf("%s_w%0d_kcex", t, i), wr_val[i], kv);
      end
   endtask

   // prod = (64*127)>>7 = 63 ; pms pattern ch0..7 = 7,1,2,3,4,5,6,2
   int m1 [8] = '{504, 1, 3, 7, 15, 31, 252, 3};
   // prod = (64*64)>>7 = 32 ; same pms pattern
   int m2 [8] = '{256, 1, 2, 4, 8, 16, 128, 2};
   localparam logic [23:0] PMS_MIX = 24'o26543217;

   initial begin
      rst = 1'b1; cen = 1'b1; start = 1'b0; lfo_pm = '0; pmd = '0;
      set_pms(PMS_MIX);
      repeat (3) tick();
      rst = 1'b0;
      check("reset_outs", out_vec(), 0);
      tick();
      check("idle_outs", out_vec(), 0);

      // positive full-depth sweep
      set_pms(PMS_MIX); lfo_pm = 8'd64; pmd = 7'd127;
      clear();
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, m1[j], 1);
      kick();
      wait_done("pos", 1, 40);
      verify("pos");
      check("pos_ndone", nd, 1);
      check("pos_done_cyc", done_cyc[0], 24);
      check("pos_busy_k", busy_log[0], 1);
      check("pos_busy_k23", busy_log[23], 1);
      check("pos_busy_k24", busy_log[24], 0);

      // negative saturation: mag 127, prod 126, pms7 clamps to 511
      set_pms(24'o77777777); lfo_pm = 8'h80; pmd = 7'd127;
      clear();
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, 511, 0);
      kick();
      wait_done("sat", 1, 40);
      verify("sat");

      // passthrough with zero depth
      set_pms(24'o17654321); lfo_pm = 8'd100; pmd = 7'd0;
      clear();
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, 0, 1);
      kick();
      wait_done("pass", 1, 40);
      verify("pass");

      // pending restart; inputs changed mid-sweep feed only the second sweep
      set_pms(PMS_MIX); lfo_pm = 8'd64; pmd = 7'd127;
      clear();
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, m1[j], 1);
      for (int j = 0; j < 8; j++) expect_wr(26 + 3 * j, j, m2[j], 0);
      kick();
      lfo_pm = 8'hC0; pmd = 7'd64;
      for (int t = 1; t < 70 && nd < 2; t++) begin
         start = (t == 3 || t == 7 || t == 11);
         tick();
      end
      start = 1'b0;
      check("pend_done_seen", 64'(nd >= 2), 1);
      repeat (6) tick();
      verify("pend");
      check("pend_ndone", nd, 2);
      check("pend_done0", done_cyc[0], 24);
      check("pend_done1", done_cyc[1], 48);
      check("pend_busy_k24", busy_log[24], 1);
      check("pend_busy_k47", busy_log[47], 1);
      check("pend_busy_k48", busy_log[48], 0);

      // reset sampled at edge k+10 aborts after three writes
      set_pms(PMS_MIX); lfo_pm = 8'd64; pmd = 7'd127;
      clear();
      kick();
      repeat (9) tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("rst_outs", out_vec(), 0);
      check("rst_nwr_before", nw, 3);
      repeat (30) tick();
      check("rst_nwr_after", nw, 3);
      check("rst_ndone", nd, 0);
      check("rst_idle_outs", out_vec(), 0);

      // cen toggling 1/0: same sequence, doubled in clk cycles
      set_pms(PMS_MIX); lfo_pm = 8'd64; pmd = 7'd127;
      clear();
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, m1[j], 1);
      kick();
      for (int t = 1; t < 120 && nd < 1; t++) begin
         cen = (t % 2 == 0);
         tick();
      end
      cen = 1'b1;
      check("cen_done_seen", 64'(nd >= 1), 1);
      repeat (4) tick();
      verify("cen");
      for (int j = 0; j < 8 && j < nw; j++)
         check($sformatf("cen_w%0d_clk", j), wr_clk[j], 2 * (2 + 3 * j) + 1);
      check("cen_we_clks", we_clks, 16);
      check("cen_done_cyc", done_cyc[0], 24);

      // channels 2 and 5 with pms=0
      set_pms(24'o77077077); lfo_pm = 8'd64; pmd = 7'd127;
      clear();
`ifdef JT51_PM_SKIP_EN
      expect_wr(2, 0, 504, 1);
      expect_wr(5, 1, 504, 1);
      expect_wr(10, 3, 504, 1);
      expect_wr(13, 4, 504, 1);
      expect_wr(18, 6, 504, 1);
      expect_wr(21, 7, 504, 1);
`else
      for (int j = 0; j < 8; j++) expect_wr(2 + 3 * j, j, (j == 2 || j == 5) ? 0 : 504, 1);
`endif
      kick();
      wait_done("skip", 1, 40);
      verify("skip");
`ifdef JT51_PM_SKIP_EN
      check("skip_done_cyc", done_cyc[0], 22);
`else
      check("skip_done_cyc", done_cyc[0], 24);
`endif
      check("skip_ndone", nd, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
